ro_meas_ctrl: RTL

Measurement sequencer for the on-chip ring-oscillator bank. It enables one of NUM_RO ring oscillators and holds it through a settle phase. It then counts synchronized rising edges of that oscillator's output over a programmable window of ro_clk cycles and returns the count through a valid/ready result port. It sits between the test/control register interface and the ring-oscillator macros, and it is the only driver of their enables.

---
 rtl/ro_meas_pkg.sv | 24 ++
 rtl/ro_edge_sync.sv | 33 +++
 rtl/ro_meas_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ro_meas_pkg.sv
// Shared types and constants for the ring-oscillator measurement sequencer.
package ro_meas_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    COUNT  = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Cycles spent after the window closes so the synchronizer pipeline empties.
  localparam int unsigned DRAIN_CYCLES = 2;

  // Depth of the oscillator synchronizer; the count qualifier is delayed by the same amount.
  localparam int unsigned SYNC_STAGES = 2;

  // Even parity over a status byte, for integrity checks on packed status words.
  function automatic logic parity8(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Synchronizer plus previous-value register producing a rising-edge strobe.
// 'load' fills the whole pipeline with the current synchronized value so that
// switching oscillators never produces a false edge.
module ro_edge_sync
  import ro_meas_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Synchronizer chain and previous-value register, reloadable to suppress spurious edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else if (load) begin
      sync_r <= {SYNC_STAGES{sync_r[SYNC_STAGES-1]}};
      prev_r <= sync_r[SYNC_STAGES-1];
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign rise = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator measurement sequencer: enables one oscillator, lets it settle,
// counts its synchronized rising edges over a programmable window and returns
// the count through a valid/ready result port.
// Build option: define RO_MEAS_SETTLE_EN to include the SETTLE phase; without it
// a request goes straight from IDLE to COUNT.
module ro_meas_ctrl
  import ro_meas_pkg::*;
#(
  parameter int NUM_RO        = 4,
  parameter int CNT_W         = 16,
  parameter int WIN_W         = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                      ro_clk,
  input  logic                      ro_rst_n,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [$clog2(NUM_RO)-1:0] sel_i,
  input  logic [WIN_W-1:0]          win_i,
  input  logic [NUM_RO-1:0]         ro_q_i,
  output logic [NUM_RO-1:0]         ro_en_o,
  output logic                      busy_o,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [CNT_W-1:0]          res_cnt_o,
  output logic [$clog2(NUM_RO)-1:0] res_sel_o,
  output logic                      res_ovf_o
);

  localparam int SEL_W = $clog2(NUM_RO);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;

  localparam logic [TMR_W-1:0] TMR_ONE    = {{(TMR_W-1){1'b0}}, 1'b1};
  localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'(DRAIN_CYCLES - 1);
`ifdef RO_MEAS_SETTLE_EN
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
`endif
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                   state_r;
  logic [SEL_W-1:0]         sel_r;
  logic [WIN_W-1:0]         win_r;
  logic [TMR_W-1:0]         tmr_r;
  logic [CNT_W-1:0]         cnt_r;
  logic                     ovf_r;
  logic [SYNC_STAGES-1:0]   cnt_dly_r;

  logic                     sel_ok;
  logic                     start_acc;
  logic                     abort_acc;
  logic [NUM_RO-1:0]        sel_onehot;
  logic                     ro_mux;
  logic                     rise;
  logic                     cnt_inc;
  logic [CNT_W-1:0]         cnt_next;
  logic                     ovf_next;

  // Request qualification: accepted starts and aborts that actually take effect.
  always_comb begin
    sel_ok    = (int'(sel_i) < NUM_RO);
    start_acc = 1'b0;
    abort_acc = 1'b0;
    if (state_r == IDLE) begin
      start_acc = start_i && sel_ok;
    end else begin
      start_acc = 1'b0;
    end
    if ((state_r == SETTLE) || (state_r == COUNT) || (state_r == DRAIN)) begin
      abort_acc = abort_i;
    end else begin
      abort_acc = 1'b0;
    end
  end

  // Decode the requested index into an enable pattern and select the active oscillator.
  always_comb begin
    sel_onehot = '0;
    ro_mux     = 1'b0;
    for (int i = 0; i < NUM_RO; i++) begin
      if (sel_i == SEL_W'(i)) begin
        sel_onehot[i] = 1'b1;
      end else begin
        sel_onehot[i] = 1'b0;
      end
      if (sel_r == SEL_W'(i)) begin
        ro_mux = ro_q_i[i];
      end else begin
        ro_mux = ro_mux;
      end
    end
  end

  ro_edge_sync u_edge_sync (
    .clk   (ro_clk),
    .rst_n (ro_rst_n),
    .load  (start_acc),
    .d     (ro_mux),
    .rise  (rise)
  );

  // Saturating next-count: edges count only while the delayed window flag is set.
  always_comb begin
    cnt_inc  = 1'b0;
    cnt_next = cnt_r;
    ovf_next = ovf_r;
    if (cnt_dly_r[SYNC_STAGES-1] && rise &&
        ((state_r == COUNT) || (state_r == DRAIN))) begin
      cnt_inc = 1'b1;
    end else begin
      cnt_inc = 1'b0;
    end
    if (cnt_inc) begin
      if (cnt_r == CNT_MAX) begin
        ovf_next = 1'b1;
      end else begin
        cnt_next = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_next = cnt_r;
    end
  end

  // Edge counter and window-flag delay line aligned with the synchronizer latency.
  always_ff @(posedge ro_clk or negedge ro_rst_n) begin
    if (!ro_rst_n) begin
      cnt_r     <= '0;
      ovf_r     <= 1'b0;
      cnt_dly_r <= '0;
    end else if (start_acc || abort_acc) begin
      cnt_r     <= '0;
      ovf_r     <= 1'b0;
      cnt_dly_r <= '0;
    end else begin
      cnt_r     <= cnt_next;
      ovf_r     <= ovf_next;
      cnt_dly_r <= {cnt_dly_r[SYNC_STAGES-2:0], (state_r == COUNT)};
    end
  end

  // Sequencer FSM with registered enables, status and result outputs.
  always_ff @(posedge ro_clk or negedge ro_rst_n) begin
    if (!ro_rst_n) begin
      state_r     <= IDLE;
      sel_r       <= '0;
      win_r       <= '0;
      tmr_r       <= '0;
      ro_en_o     <= '0;
      busy_o      <= 1'b0;
      res_valid_o <= 1'b0;
      res_cnt_o   <= '0;
      res_sel_o   <= '0;
      res_ovf_o   <= 1'b0;
    end else if (abort_acc) begin
      state_r <= IDLE;
      tmr_r   <= '0;
      ro_en_o <= '0;
      busy_o  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_acc) begin
            sel_r  <= sel_i;
            win_r  <= win_i;
            busy_o <= 1'b1;
`ifdef RO_MEAS_SETTLE_EN
            state_r <= SETTLE;
            tmr_r   <= SETTLE_LOAD;
            ro_en_o <= sel_onehot;
`else
            if (win_i == '0) begin
              state_r <= DRAIN;
              tmr_r   <= DRAIN_LOAD;
              ro_en_o <= '0;
            end else begin
              state_r <= COUNT;
              tmr_r   <= TMR_W'(win_i) - TMR_ONE;
              ro_en_o <= sel_onehot;
            end
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        SETTLE: begin
          if (tmr_r != '0) begin
            tmr_r <= tmr_r - TMR_ONE;
          end else if (win_r == '0) begin
            state_r <= DRAIN;
            tmr_r   <= DRAIN_LOAD;
            ro_en_o <= '0;
          end else begin
            state_r <= COUNT;
            tmr_r   <= TMR_W'(win_r) - TMR_ONE;
          end
        end
        COUNT: begin
          if (tmr_r != '0) begin
            tmr_r <= tmr_r - TMR_ONE;
          end else begin
            state_r <= DRAIN;
            tmr_r   <= DRAIN_LOAD;
            ro_en_o <= '0;
          end
        end
        DRAIN: begin
          if (tmr_r != '0) begin
            tmr_r <= tmr_r - TMR_ONE;
          end else begin
            state_r     <= DONE;
            res_valid_o <= 1'b1;
            res_cnt_o   <= cnt_next;
            res_ovf_o   <= ovf_next;
            res_sel_o   <= sel_r;
          end
        end
        DONE: begin
          if (res_ready_i) begin
            state_r     <= IDLE;
            res_valid_o <= 1'b0;
            busy_o      <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          tmr_r       <= '0;
          ro_en_o     <= '0;
          busy_o      <= 1'b0;
          res_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
